dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder for the in-order RV64 pipeline. It serves the load/store requests issued by the execute stage. It returns a 64-bit read word that the memory stage consumes in the following cycle. It is a synchronous SRAM model with byte-lane write masks and a configurable wait-state engine, and it asserts a stall request toward the pipeline controller while an access is outstanding.

Parameters:
DEPTH_LOG2, 12, number of 64-bit words = 2**DEPTH_LOG2
WAIT_CYCLES, 0, extra access latency in cycles, legal 0..7
BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_en  input  1  access request from execute stage
req_we  input  1  1 = store, 0 = load
req_sel  input  8  byte-lane enables, bit i = byte i of the 64-bit word
req_addr  input  64  byte address; bits [2:0] ignored
req_wdata  input  64  store data, already lane-aligned
rdata  output  64  read word, consumed by the memory stage
resp_valid  output  1  pulse marking the cycle rdata is updated for an accepted load
stall_req  output  1  pipeline stall request while an access is in wait states
err  output  1  access-fault pulse (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge): rdata=0, resp_valid=0, stall_req=0, err=0, state=IDLE, wait counter=0. Array contents are not reset. Reset during WAIT aborts the access; a store already committed remains.
- Index = (req_addr - BASE_ADDR)[DEPTH_LOG2+2:3].
- States: IDLE, WAIT.
- IDLE with req_en=1 (accept edge):
  - Store: for each i with req_sel[i]=1, byte i of mem[index] <= req_wdata[8i+7:8i]. Other bytes are unchanged. The commit happens at the accept edge.
  - Load: the index and request are latched.
  - WAIT_CYCLES=0: a load writes rdata <= mem[index] at the accept edge. The read returns the old data for that edge, so stores are not forwarded within the same edge. resp_valid=1 for the next cycle. State stays IDLE. stall_req stays 0.
  - WAIT_CYCLES=N>0: counter <= N, state <= WAIT. stall_req=1 from the cycle after accept for exactly N cycles.
- WAIT: counter decrements each cycle. When counter==1 at a posedge:
  - A load captures rdata <= mem[latched index].
  - resp_valid pulses for the next cycle.
  - State returns to IDLE and stall_req deasserts.
  - Requests presented during WAIT are ignored. The pipeline holds them stable under stall.
- Load-after-store to the same word on consecutive accepted requests returns the merged (post-store) data.
- rdata holds its value until the next accepted load. Stores, idle cycles and stall cycles do not change it.
- Back-to-back: a request present in the cycle state returns to IDLE is accepted at the next posedge. There are no bubbles beyond the WAIT_CYCLES penalty.
- req_en=1 with req_sel=0:
  - Load: performed normally (full word returned).
  - Store: no-op.
- stall_req is registered, never combinational from inputs.

Optional Feature:
DMEM_RANGE_CHECK_EN
- Defined: an accepted request with req_addr outside [BASE_ADDR, BASE_ADDR + 8*2**DEPTH_LOG2) is faulted:
  - The store is suppressed.
  - The load returns rdata=0.
  - err pulses in the same cycle resp_valid would (stores included).
  - Wait-state timing is unchanged.
- Undefined: the index wraps modulo depth and err is tied to 0.

Test Plan:
- WAIT_CYCLES=0: store 64'h1122334455667788 sel=8'hFF to BASE_ADDR, then load BASE_ADDR -> rdata=64'h1122334455667788 with resp_valid=1 one cycle after the load accept, stall_req always 0.
- Byte-mask merge: after the above, store 64'h000000AA00000000 sel=8'h10 to BASE_ADDR, then load -> rdata=64'h112233AA55667788.
- WAIT_CYCLES=3: load accepted at cycle t -> stall_req=1 in cycles t+1..t+3, resp_valid=1 at t+4, rdata stable thereafter; a request held at inputs during t+1..t+3 is not re-accepted.
- Reset mid-WAIT: assert rst_n=0 at t+2 of a 3-wait load -> next cycle rdata=0, stall_req=0, resp_valid=0; a store committed before reset reads back intact after reset.
- Back-to-back loads A then B (WAIT_CYCLES=0, A holds 64'h1, B holds 64'h2) -> rdata=1 then 2 on consecutive cycles, resp_valid high both cycles.
- DMEM_RANGE_CHECK_EN, DEPTH_LOG2=12: store to BASE_ADDR+64'h8000 -> err=1 and memory unchanged; load from the same address -> rdata=0, err=1.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the in-order RV64 pipeline. It models a
//   synchronous SRAM of 2**DEPTH_LOG2 64-bit words with byte-lane write
//   masks. A wait-state engine adds WAIT_CYCLES of latency to each access and
//   raises a registered stall request while the access is outstanding.
//
// Parameters
//   DEPTH_LOG2  : log2 of the number of 64-bit words
//   WAIT_CYCLES : extra access latency in cycles (0..7)
//   BASE_ADDR   : byte address of word 0
//
// Ports
//   clk        : clock
//   rst_n      : synchronous active-low reset (control and rdata only;
//                the array is not reset)
//   req_en     : access request from the execute stage
//   req_we     : 1 = store, 0 = load
//   req_sel    : byte-lane enables, bit i = byte i of the word
//   req_addr   : byte address, bits [2:0] ignored
//   req_wdata  : lane-aligned store data
//   rdata      : read word, held until the next accepted load
//   resp_valid : one-cycle pulse when rdata is updated by a load
//   stall_req  : registered stall request during wait states
//   err        : access-fault pulse (range-check build only)
//
// Build option
//   DMEM_RANGE_CHECK_EN : when defined, accesses outside the mapped window
//   are faulted (store suppressed, load returns 0, err pulses). When
//   undefined the index wraps modulo the depth and err is tied to 0.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_en,
    input  logic        req_we,
    input  logic [7:0]  req_sel,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [63:0] rdata,
    output logic        resp_valid,
    output logic        stall_req,
    output logic        err
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [63:0] mem [DEPTH];

    // Request decode (p0) and the copy latched at the accept edge (p1)
    logic [63:0]           addr_off_p0;
    logic [DEPTH_LOG2-1:0] idx_p0;
    logic                  fault_p0;
    logic [DEPTH_LOG2-1:0] idx_p1;
    logic                  we_p1;
    logic                  fault_p1;

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [63:0]           rd_word;
    logic                  accept;
    logic [63:0]           rdata_d;
    logic                  resp_valid_d;
    logic                  stall_d;
    logic                  err_d;
    logic                  err_q;

    // Subtracting the base first makes addresses below BASE_ADDR wrap to
    // huge offsets, so one unsigned compare covers both ends of the window.
    assign addr_off_p0 = req_addr - BASE_ADDR;
    assign idx_p0      = addr_off_p0[DEPTH_LOG2+2:3];

`ifdef DMEM_RANGE_CHECK_EN
    assign fault_p0 = (addr_off_p0 >> (DEPTH_LOG2 + 3)) != 64'd0;
    assign err      = err_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_off_p0[2:0];
`else
    assign fault_p0 = 1'b0;
    assign err      = 1'b0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_off_p0[63:DEPTH_LOG2+3], addr_off_p0[2:0], err_q};
`endif

    // The idle read port looks at the incoming request; during wait states
    // it looks at the latched one so the final capture sees any store that
    // landed after the accept edge.
    assign rd_word = mem[rd_idx];

    // ---- state register -----------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            rdata      <= 64'd0;
            resp_valid <= 1'b0;
            stall_req  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata      <= rdata_d;
            resp_valid <= resp_valid_d;
            stall_req  <= stall_d;
            err_q      <= err_d;
        end
    end

    // ---- next-state and registered-output logic -------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata;
        resp_valid_d = 1'b0;
        stall_d      = stall_req;
        err_d        = 1'b0;
        accept       = 1'b0;
        rd_idx       = idx_p1;

        case (state_q)
            S_IDLE: begin
                rd_idx  = idx_p0;
                stall_d = 1'b0;
                if (req_en) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        err_d = fault_p0;
                        if (!req_we) begin
                            rdata_d      = fault_p0 ? 64'd0 : rd_word;
                            resp_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                        stall_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_IDLE;
                    stall_d = 1'b0;
                    err_d   = fault_p1;
                    if (!we_p1) begin
                        rdata_d      = fault_p1 ? 64'd0 : rd_word;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                stall_d = 1'b0;
            end
        endcase
    end

    // ---- accept stage: latch request for the wait-state engine ----------
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p1   <= idx_p0;
            we_p1    <= req_we;
            fault_p1 <= fault_p0;
        end
    end

    // ---- accept stage: store commit ---------------------------------------
    // Stores land at the accept edge regardless of wait states; the array
    // has no reset so a committed store survives a later reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept && req_we && !fault_p0) begin
            for (int i = 0; i < 8; i++) begin
                if (req_sel[i]) begin
                    mem[idx_p0][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench with two responders: dut0 (no wait states) and dut3
//   (three wait states). Each scenario task drives stimulus and checks the
//   outputs one time unit after the active clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_en, a_we;
    logic [7:0]  a_sel;
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic        a_rv, a_stall, a_err;

    logic        b_en, b_we;
    logic [7:0]  b_sel;
    logic [63:0] b_addr, b_wdata, b_rdata;
    logic        b_rv, b_stall, b_err;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_en(a_en), .req_we(a_we), .req_sel(a_sel),
        .req_addr(a_addr), .req_wdata(a_wdata), .rdata(a_rdata),
        .resp_valid(a_rv), .stall_req(a_stall), .err(a_err)
    );

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3), .BASE_ADDR(BASE)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_en(b_en), .req_we(b_we), .req_sel(b_sel),
        .req_addr(b_addr), .req_wdata(b_wdata), .rdata(b_rdata),
        .resp_valid(b_rv), .stall_req(b_stall), .err(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic we, input logic [7:0] sel, input logic [63:0] addr,
                         input logic [63:0] wd);
        a_en = 1'b1; a_we = we; a_sel = sel; a_addr = addr; a_wdata = wd;
    endtask

    task automatic b_req(input logic we, input logic [7:0] sel, input logic [63:0] addr,
                         input logic [63:0] wd);
        b_en = 1'b1; b_we = we; b_sel = sel; b_addr = addr; b_wdata = wd;
    endtask

    task automatic a_idle();
        a_en = 1'b0; a_we = 1'b0; a_sel = 8'h00; a_addr = BASE; a_wdata = 64'd0;
    endtask

    task automatic b_idle();
        b_en = 1'b0; b_we = 1'b0; b_sel = 8'h00; b_addr = BASE; b_wdata = 64'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_idle();
        b_idle();
        step();
        step();
        n_cmp++; if ({a_rdata, a_rv, a_stall, a_err} !== 67'd0) begin n_fail++;
            $display("FAIL reset_dut0: got rdata=%h rv=%b stall=%b err=%b expected all zero", a_rdata, a_rv, a_stall, a_err); end
        n_cmp++; if ({b_rdata, b_rv, b_stall, b_err} !== 67'd0) begin n_fail++;
            $display("FAIL reset_dut3: got rdata=%h rv=%b stall=%b err=%b expected all zero", b_rdata, b_rv, b_stall, b_err); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (a_stall !== 1'b0) begin n_fail++;
            $display("FAIL reset_release_stall: got %b expected 0", a_stall); end
    endtask

    task automatic test_store_load();
        a_req(1'b1, 8'hFF, BASE, 64'h1122334455667788);
        step();
        n_cmp++; if (a_rv !== 1'b0) begin n_fail++;
            $display("FAIL store_no_resp: got rv=%b expected 0", a_rv); end
        n_cmp++; if (a_stall !== 1'b0) begin n_fail++;
            $display("FAIL store_w0_stall: got %b expected 0", a_stall); end
        a_req(1'b0, 8'hFF, BASE, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'h1122334455667788) begin n_fail++;
            $display("FAIL load_rdata: got %h expected %h", a_rdata, 64'h1122334455667788); end
        n_cmp++; if (a_rv !== 1'b1) begin n_fail++;
            $display("FAIL load_resp_valid: got %b expected 1", a_rv); end
        n_cmp++; if (a_stall !== 1'b0) begin n_fail++;
            $display("FAIL load_w0_stall: got %b expected 0", a_stall); end
        a_idle();
        step();
        n_cmp++; if (a_rv !== 1'b0) begin n_fail++;
            $display("FAIL idle_resp_valid: got %b expected 0", a_rv); end
        n_cmp++; if (a_rdata !== 64'h1122334455667788) begin n_fail++;
            $display("FAIL idle_rdata_hold: got %h expected %h", a_rdata, 64'h1122334455667788); end
    endtask

    task automatic test_byte_merge();
        a_req(1'b1, 8'h10, BASE, 64'h000000AA00000000);
        step();
        n_cmp++; if (a_rdata !== 64'h1122334455667788) begin n_fail++;
            $display("FAIL store_keeps_rdata: got %h expected %h", a_rdata, 64'h1122334455667788); end
        a_req(1'b0, 8'hFF, BASE, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'h112233AA55667788) begin n_fail++;
            $display("FAIL merge_rdata: got %h expected %h", a_rdata, 64'h112233AA55667788); end
        n_cmp++; if (a_rv !== 1'b1) begin n_fail++;
            $display("FAIL merge_resp_valid: got %b expected 1", a_rv); end
    endtask

    task automatic test_sel_zero();
        a_req(1'b1, 8'h00, BASE, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        a_req(1'b0, 8'h00, BASE, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'h112233AA55667788) begin n_fail++;
            $display("FAIL sel0_rdata: got %h expected %h", a_rdata, 64'h112233AA55667788); end
        n_cmp++; if (a_rv !== 1'b1) begin n_fail++;
            $display("FAIL sel0_resp_valid: got %b expected 1", a_rv); end
        a_idle();
    endtask

    task automatic test_back_to_back();
        a_req(1'b1, 8'hFF, BASE + 64'd8, 64'd1);
        step();
        a_req(1'b1, 8'hFF, BASE + 64'd16, 64'd2);
        step();
        a_req(1'b0, 8'hFF, BASE + 64'd8, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'd1 || a_rv !== 1'b1) begin n_fail++;
            $display("FAIL b2b_first: got rdata=%h rv=%b expected rdata=1 rv=1", a_rdata, a_rv); end
        a_req(1'b0, 8'hFF, BASE + 64'd16, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'd2 || a_rv !== 1'b1) begin n_fail++;
            $display("FAIL b2b_second: got rdata=%h rv=%b expected rdata=2 rv=1", a_rdata, a_rv); end
        a_idle();
        step();
        n_cmp++; if (a_rdata !== 64'd2 || a_rv !== 1'b0) begin n_fail++;
            $display("FAIL b2b_after: got rdata=%h rv=%b expected rdata=2 rv=0", a_rdata, a_rv); end
    endtask

    task automatic test_wait_states();
        // Store with wait states: stall for three cycles, no response pulse.
        b_req(1'b1, 8'hFF, BASE + 64'd32, 64'hDEAD_BEEF_0BAD_F00D);
        step();
        b_idle();
        n_cmp++; if (b_stall !== 1'b1) begin n_fail++;
            $display("FAIL w3_store_stall_t1: got %b expected 1", b_stall); end
        step();
        step();
        n_cmp++; if (b_stall !== 1'b1) begin n_fail++;
            $display("FAIL w3_store_stall_t3: got %b expected 1", b_stall); end
        step();
        n_cmp++; if (b_stall !== 1'b0 || b_rv !== 1'b0) begin n_fail++;
            $display("FAIL w3_store_end: got stall=%b rv=%b expected stall=0 rv=0", b_stall, b_rv); end

        b_req(1'b1, 8'hFF, BASE + 64'd40, 64'h55);
        step();
        b_idle();
        step();
        step();
        step();

        // Load held at the inputs for the whole wait window.
        b_req(1'b0, 8'hFF, BASE + 64'd32, 64'd0);
        step();
        n_cmp++; if (b_stall !== 1'b1 || b_rv !== 1'b0) begin n_fail++;
            $display("FAIL w3_load_t1: got stall=%b rv=%b expected stall=1 rv=0", b_stall, b_rv); end
        for (int k = 2; k <= 3; k++) begin
            step();
            n_cmp++; if (b_stall !== 1'b1 || b_rv !== 1'b0) begin n_fail++;
                $display("FAIL w3_load_t%0d: got stall=%b rv=%b expected stall=1 rv=0", k, b_stall, b_rv); end
        end
        step();
        n_cmp++; if (b_stall !== 1'b0 || b_rv !== 1'b1) begin n_fail++;
            $display("FAIL w3_load_t4: got stall=%b rv=%b expected stall=0 rv=1", b_stall, b_rv); end
        n_cmp++; if (b_rdata !== 64'hDEAD_BEEF_0BAD_F00D) begin n_fail++;
            $display("FAIL w3_load_rdata: got %h expected %h", b_rdata, 64'hDEAD_BEEF_0BAD_F00D); end

        // Next request presented in the return-to-idle cycle: no bubble.
        b_req(1'b0, 8'hFF, BASE + 64'd40, 64'd0);
        step();
        n_cmp++; if (b_stall !== 1'b1 || b_rv !== 1'b0) begin n_fail++;
            $display("FAIL w3_b2b_stall: got stall=%b rv=%b expected stall=1 rv=0", b_stall, b_rv); end
        n_cmp++; if (b_rdata !== 64'hDEAD_BEEF_0BAD_F00D) begin n_fail++;
            $display("FAIL w3_rdata_stable: got %h expected %h", b_rdata, 64'hDEAD_BEEF_0BAD_F00D); end
        step();
        step();
        step();
        n_cmp++; if (b_rdata !== 64'h55 || b_rv !== 1'b1 || b_stall !== 1'b0) begin n_fail++;
            $display("FAIL w3_b2b_resp: got rdata=%h rv=%b stall=%b expected rdata=55 rv=1 stall=0", b_rdata, b_rv, b_stall); end
        b_idle();
        step();
        n_cmp++; if (b_rdata !== 64'h55 || b_rv !== 1'b0 || b_stall !== 1'b0) begin n_fail++;
            $display("FAIL w3_after: got rdata=%h rv=%b stall=%b expected rdata=55 rv=0 stall=0", b_rdata, b_rv, b_stall); end
    endtask

    task automatic test_reset_mid_wait();
        b_req(1'b0, 8'hFF, BASE + 64'd32, 64'd0);
        step();
        step();
        rst_n = 1'b0;
        step();
        n_cmp++; if ({b_rdata, b_rv, b_stall} !== 66'd0) begin n_fail++;
            $display("FAIL midwait_reset: got rdata=%h rv=%b stall=%b expected all zero", b_rdata, b_rv, b_stall); end
        rst_n = 1'b1;
        b_idle();
        step();
        n_cmp++; if (b_stall !== 1'b0 || b_rv !== 1'b0) begin n_fail++;
            $display("FAIL midwait_after: got stall=%b rv=%b expected 0 0", b_stall, b_rv); end
        b_req(1'b0, 8'hFF, BASE + 64'd32, 64'd0);
        step();
        b_idle();
        step();
        step();
        step();
        n_cmp++; if (b_rdata !== 64'hDEAD_BEEF_0BAD_F00D || b_rv !== 1'b1) begin n_fail++;
            $display("FAIL midwait_readback: got rdata=%h rv=%b expected %h rv=1", b_rdata, b_rv, 64'hDEAD_BEEF_0BAD_F00D); end
    endtask

    task automatic test_range();
`ifdef DMEM_RANGE_CHECK_EN
        a_req(1'b1, 8'hFF, BASE + 64'h8000, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        n_cmp++; if (a_err !== 1'b1 || a_rv !== 1'b0) begin n_fail++;
            $display("FAIL range_store_err: got err=%b rv=%b expected err=1 rv=0", a_err, a_rv); end
        a_idle();
        step();
        n_cmp++; if (a_err !== 1'b0) begin n_fail++;
            $display("FAIL range_err_pulse: got %b expected 0", a_err); end
        a_req(1'b0, 8'hFF, BASE, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'h112233AA55667788 || a_err !== 1'b0) begin n_fail++;
            $display("FAIL range_mem_intact: got rdata=%h err=%b expected %h err=0", a_rdata, a_err, 64'h112233AA55667788); end
        a_req(1'b0, 8'hFF, BASE + 64'h8000, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'd0 || a_err !== 1'b1 || a_rv !== 1'b1) begin n_fail++;
            $display("FAIL range_load: got rdata=%h err=%b rv=%b expected 0 1 1", a_rdata, a_err, a_rv); end
        a_idle();
        b_req(1'b1, 8'hFF, BASE - 64'd8, 64'd7);
        step();
        b_idle();
        n_cmp++; if (b_err !== 1'b0) begin n_fail++;
            $display("FAIL range_w3_err_early: got %b expected 0", b_err); end
        step();
        step();
        step();
        n_cmp++; if (b_err !== 1'b1 || b_stall !== 1'b0) begin n_fail++;
            $display("FAIL range_w3_err: got err=%b stall=%b expected err=1 stall=0", b_err, b_stall); end
`else
        a_req(1'b1, 8'hFF, BASE + 64'h8000, 64'hCAFE);
        step();
        n_cmp++; if (a_err !== 1'b0) begin n_fail++;
            $display("FAIL wrap_store_err: got %b expected 0", a_err); end
        a_req(1'b0, 8'hFF, BASE, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'hCAFE || a_err !== 1'b0) begin n_fail++;
            $display("FAIL wrap_alias: got rdata=%h err=%b expected CAFE err=0", a_rdata, a_err); end
        a_req(1'b0, 8'hFF, BASE + 64'h8000, 64'd0);
        step();
        n_cmp++; if (a_rdata !== 64'hCAFE || a_rv !== 1'b1) begin n_fail++;
            $display("FAIL wrap_load: got rdata=%h rv=%b expected CAFE rv=1", a_rdata, a_rv); end
        a_idle();
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_merge();
        test_sel_zero();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_wait();
        test_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
